// File: rtl/mem_lsu.sv
// MEM stage load/store unit: drives a req/ready/rvalid data-memory port, lane-aligns
// store data, extracts and extends load data, and stalls upstream while an access is open.
module mem_lsu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vld,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_opsel,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [31:0] i_res,
    input  logic [4:0]  i_rd_waddr,
    input  logic        i_rd_wen,
    input  logic        i_mem_reg,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_vld,
    output logic [4:0]  o_rd_waddr,
    output logic        o_rd_wen,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t state_reg, state_next;

    logic        mem_op;
    logic        misaligned;
    logic        latch;
    logic [31:0] st_wdata;
    logic [3:0]  st_mask;

    // Request fields captured at issue so REQ/WAIT no longer depend on the inputs' lanes.
    logic        lat_wen_reg;
    logic [31:0] lat_addr_reg;
    logic [31:0] lat_wdata_reg;
    logic [3:0]  lat_mask_reg;
    logic [1:0]  lat_off_reg;
    logic [2:0]  lat_opsel_reg;
    logic [4:0]  lat_rd_waddr_reg;
    logic        lat_rd_wen_reg;
    logic        lat_mem_reg_reg;

    logic        vld_reg, vld_next;
    logic [4:0]  rd_waddr_reg, rd_waddr_next;
    logic        rd_wen_reg, rd_wen_next;
    logic [31:0] wb_data_reg, wb_data_next;
    logic        mis_reg, mis_next;

    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign mem_op     = i_vld & (i_mem_read | i_mem_write);
    assign misaligned = ((i_opsel[1:0] == 2'b01) & i_dmem_addr[0]) |
                        ((i_opsel[1:0] == 2'b10) & (i_dmem_addr[1:0] != 2'b00));

    // Byte lane gi: replicate the narrow store datum across lanes, enable only the addressed bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign st_wdata[8*gi +: 8] = (i_opsel[1:0] == 2'b00) ? i_dmem_wdata[7:0] :
                                         (i_opsel[1:0] == 2'b01) ? i_dmem_wdata[8*(gi%2) +: 8] :
                                                                   i_dmem_wdata[8*gi +: 8];
            assign st_mask[gi] = ~i_mem_write |
                                 ((i_opsel[1:0] == 2'b00) ? (i_dmem_addr[1:0] == 2'(gi)) :
                                  (i_opsel[1:0] == 2'b01) ? (i_dmem_addr[1] == 1'(gi/2)) :
                                                            1'b1);
        end
    endgenerate

    assign shifted = i_dmem_rdata >> {lat_off_reg, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (lat_opsel_reg)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        o_stall       = 1'b0;
        o_dmem_req    = 1'b0;
        o_dmem_wen    = i_mem_write;
        o_dmem_addr   = {i_dmem_addr[31:2], 2'b00};
        o_dmem_wdata  = st_wdata;
        o_dmem_mask   = st_mask;
        latch         = 1'b0;
        vld_next      = 1'b0;
        rd_wen_next   = 1'b0;
        mis_next      = 1'b0;
        rd_waddr_next = rd_waddr_reg;
        wb_data_next  = wb_data_reg;
        case (state_reg)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    o_dmem_req = 1'b1;
                    latch      = 1'b1;
                    if (i_dmem_ready && i_mem_write) begin
                        vld_next      = 1'b1;
                        rd_wen_next   = i_rd_wen;
                        rd_waddr_next = i_rd_waddr;
                        wb_data_next  = i_res;
                    end else begin
                        o_stall    = 1'b1;
                        state_next = i_dmem_ready ? WAIT : REQ;
                    end
                end else if (mem_op) begin
                    vld_next      = 1'b1;
                    mis_next      = 1'b1;
                    rd_waddr_next = i_rd_waddr;
                end else if (i_vld) begin
                    vld_next      = 1'b1;
                    rd_wen_next   = i_rd_wen;
                    rd_waddr_next = i_rd_waddr;
                    wb_data_next  = i_res;
                end
            end
            REQ: begin
                o_dmem_req   = 1'b1;
                o_dmem_wen   = lat_wen_reg;
                o_dmem_addr  = lat_addr_reg;
                o_dmem_wdata = lat_wdata_reg;
                o_dmem_mask  = lat_mask_reg;
                if (i_dmem_ready && lat_wen_reg) begin
                    vld_next      = 1'b1;
                    rd_wen_next   = lat_rd_wen_reg;
                    rd_waddr_next = lat_rd_waddr_reg;
                    wb_data_next  = i_res;
                    state_next    = IDLE;
                end else begin
                    o_stall = 1'b1;
                    if (i_dmem_ready) state_next = WAIT;
                end
            end
            WAIT: begin
                o_dmem_wen   = lat_wen_reg;
                o_dmem_addr  = lat_addr_reg;
                o_dmem_wdata = lat_wdata_reg;
                o_dmem_mask  = lat_mask_reg;
                if (i_dmem_rvalid) begin
                    vld_next      = 1'b1;
                    rd_wen_next   = lat_rd_wen_reg;
                    rd_waddr_next = lat_rd_waddr_reg;
                    wb_data_next  = lat_mem_reg_reg ? load_ext : i_res;
                    state_next    = IDLE;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Reset abandons any access, so nothing may be requested or stalled while it is held.
        if (i_rst) begin
            o_stall    = 1'b0;
            o_dmem_req = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            vld_reg      <= 1'b0;
            rd_waddr_reg <= 5'd0;
            rd_wen_reg   <= 1'b0;
            wb_data_reg  <= 32'd0;
            mis_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            vld_reg      <= vld_next;
            rd_waddr_reg <= rd_waddr_next;
            rd_wen_reg   <= rd_wen_next;
            wb_data_reg  <= wb_data_next;
            mis_reg      <= mis_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (latch) begin
            lat_wen_reg      <= i_mem_write;
            lat_addr_reg     <= {i_dmem_addr[31:2], 2'b00};
            lat_wdata_reg    <= st_wdata;
            lat_mask_reg     <= st_mask;
            lat_off_reg      <= i_dmem_addr[1:0];
            lat_opsel_reg    <= i_opsel;
            lat_rd_waddr_reg <= i_rd_waddr;
            lat_rd_wen_reg   <= i_rd_wen;
            lat_mem_reg_reg  <= i_mem_reg;
        end
    end

    assign o_vld        = vld_reg;
    assign o_rd_waddr   = rd_waddr_reg;
    assign o_rd_wen     = rd_wen_reg;
    assign o_wb_data    = wb_data_reg;
    assign o_misaligned = mis_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: expected MEM/WB entries are queued when an op is driven
// and popped when the DUT presents o_vld; memory-port behaviour is checked cycle by cycle.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_vld, i_mem_read, i_mem_write;
    logic [2:0]  i_opsel;
    logic [31:0] i_dmem_addr, i_dmem_wdata, i_res;
    logic [4:0]  i_rd_waddr;
    logic        i_rd_wen, i_mem_reg;
    logic        o_stall, o_dmem_req, o_dmem_wen;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic        i_dmem_ready, i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_vld;
    logic [4:0]  o_rd_waddr;
    logic        o_rd_wen;
    logic [31:0] o_wb_data;
    logic        o_misaligned;

    typedef struct packed {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
        logic        chk;   // compare rd/wb_data only where the value is architecturally defined
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_opsel(i_opsel), .i_dmem_addr(i_dmem_addr),
        .i_dmem_wdata(i_dmem_wdata), .i_res(i_res), .i_rd_waddr(i_rd_waddr),
        .i_rd_wen(i_rd_wen), .i_mem_reg(i_mem_reg), .o_stall(o_stall),
        .o_dmem_req(o_dmem_req), .o_dmem_wen(o_dmem_wen), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_mask(o_dmem_mask), .i_dmem_ready(i_dmem_ready),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata), .o_vld(o_vld),
        .o_rd_waddr(o_rd_waddr), .o_rd_wen(o_rd_wen), .o_wb_data(o_wb_data),
        .o_misaligned(o_misaligned)
    );

    task automatic drive(input logic vld, input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] res,
                         input logic [4:0] rdw, input logic wen, input logic mreg);
        i_vld = vld; i_mem_read = rd; i_mem_write = wr; i_opsel = op;
        i_dmem_addr = addr; i_dmem_wdata = wdata; i_res = res;
        i_rd_waddr = rdw; i_rd_wen = wen; i_mem_reg = mreg;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        #1;
        n_checks++;
        if ({o_vld, o_rd_wen, o_misaligned, o_rd_waddr, o_wb_data} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_wb: got vld=%b wen=%b mis=%b rd=%0d data=%h want all zero",
                     o_vld, o_rd_wen, o_misaligned, o_rd_waddr, o_wb_data);
        end
        n_checks++;
        if ({o_dmem_req, o_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_port: got req=%b stall=%b want 0 0", o_dmem_req, o_stall);
        end
    endtask

    task automatic test_alu_back_to_back();
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b1, 1'b0);
        sb.push_back('{wb: 32'h1234_5678, rd: 5'd5, wen: 1'b1, mis: 1'b0, chk: 1'b1});
        #1;
        n_checks++;
        if (o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL alu1_port: got stall=%b req=%b want 0 0", o_stall, o_dmem_req);
        end
        @(posedge clk); #1;
        n_checks++;
        e = sb.pop_front();
        if (o_vld !== 1'b1 || o_rd_wen !== e.wen || o_misaligned !== e.mis || o_rd_waddr !== e.rd || o_wb_data !== e.wb) begin
            n_fail++;
            $display("FAIL alu1_wb: got vld=%b wen=%b mis=%b rd=%0d data=%h want vld=1 wen=%b mis=%b rd=%0d data=%h",
                     o_vld, o_rd_wen, o_misaligned, o_rd_waddr, o_wb_data, e.wen, e.mis, e.rd, e.wb);
        end
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFE_0000, 5'd6, 1'b1, 1'b0);
        sb.push_back('{wb: 32'hCAFE_0000, rd: 5'd6, wen: 1'b1, mis: 1'b0, chk: 1'b1});
        #1;
        n_checks++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu2_stall: got %b want 0", o_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        e = sb.pop_front();
        if (o_vld !== 1'b1 || o_rd_wen !== e.wen || o_misaligned !== e.mis || o_rd_waddr !== e.rd || o_wb_data !== e.wb) begin
            n_fail++;
            $display("FAIL alu2_wb: got vld=%b wen=%b mis=%b rd=%0d data=%h want vld=1 wen=%b mis=%b rd=%0d data=%h",
                     o_vld, o_rd_wen, o_misaligned, o_rd_waddr, o_wb_data, e.wen, e.mis, e.rd, e.wb);
        end
        drive_idle();
        @(posedge clk); #1;
        n_checks++;
        if (o_vld !== 1'b0 || o_rd_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_bubble: got vld=%b wen=%b want 0 0", o_vld, o_rd_wen);
        end
    endtask

    task automatic test_store_byte();
        @(posedge clk); #1;
        i_dmem_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h103, 32'h1234_56AA, 32'h103, 5'd0, 1'b0, 1'b0);
        sb.push_back('{wb: 32'h0, rd: 5'd0, wen: 1'b0, mis: 1'b0, chk: 1'b0});
        #1;
        n_checks++;
        if ({o_dmem_req, o_dmem_wen, o_dmem_addr, o_dmem_mask, o_dmem_wdata, o_stall} !==
            {1'b1, 1'b1, 32'h100, 4'b1000, 32'hAAAA_AAAA, 1'b0}) begin
            n_fail++;
            $display("FAIL sb_port: got req=%b wen=%b addr=%h mask=%b wdata=%h stall=%b want 1 1 00000100 1000 aaaaaaaa 0",
                     o_dmem_req, o_dmem_wen, o_dmem_addr, o_dmem_mask, o_dmem_wdata, o_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        e = sb.pop_front();
        if (o_vld !== 1'b1 || o_rd_wen !== e.wen || o_misaligned !== e.mis) begin
            n_fail++;
            $display("FAIL sb_wb: got vld=%b wen=%b mis=%b want vld=1 wen=%b mis=%b",
                     o_vld, o_rd_wen, o_misaligned, e.wen, e.mis);
        end
        drive_idle();
        i_dmem_ready = 1'b0;
    endtask

    task automatic test_load_byte();
        logic exp_stall, exp_req;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h102, 5'd7, 1'b1, 1'b1);
        sb.push_back('{wb: 32'hFFFF_FF80, rd: 5'd7, wen: 1'b1, mis: 1'b0, chk: 1'b1});
        for (int c = 0; c < 6; c++) begin
            i_dmem_ready  = (c == 2);
            i_dmem_rvalid = (c == 5);
            i_dmem_rdata  = (c == 5) ? 32'h0080_0000 : 32'h0;
            exp_stall = (c < 5);
            exp_req   = (c <= 2);
            #1;
            n_checks++;
            if (o_stall !== exp_stall || o_dmem_req !== exp_req ||
                (exp_req && (o_dmem_addr !== 32'h100 || o_dmem_wen !== 1'b0 || o_dmem_mask !== 4'hF)) ||
                (c > 0 && o_vld !== 1'b0)) begin
                n_fail++;
                $display("FAIL lb_cycle%0d: got stall=%b req=%b addr=%h wen=%b mask=%b vld=%b want stall=%b req=%b addr=00000100 wen=0 mask=1111 vld=0",
                         c, o_stall, o_dmem_req, o_dmem_addr, o_dmem_wen, o_dmem_mask, o_vld, exp_stall, exp_req);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        e = sb.pop_front();
        if (o_vld !== 1'b1 || o_rd_wen !== e.wen || o_misaligned !== e.mis || o_rd_waddr !== e.rd || o_wb_data !== e.wb) begin
            n_fail++;
            $display("FAIL lb_wb: got vld=%b wen=%b mis=%b rd=%0d data=%h want vld=1 wen=%b mis=%b rd=%0d data=%h",
                     o_vld, o_rd_wen, o_misaligned, o_rd_waddr, o_wb_data, e.wen, e.mis, e.rd, e.wb);
        end
        drive_idle();
        i_dmem_rvalid = 1'b0;
    endtask

    task automatic test_half_and_misaligned();
        // LHU then LH of the same halfword value: zero- versus sign-extension.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            drive(1'b1, 1'b1, 1'b0, (k == 0) ? 3'b101 : 3'b001, 32'h202, 32'h0, 32'h202, 5'd8, 1'b1, 1'b1);
            i_dmem_ready = 1'b1;
            sb.push_back('{wb: (k == 0) ? 32'h0000_8001 : 32'hFFFF_8001, rd: 5'd8, wen: 1'b1, mis: 1'b0, chk: 1'b1});
            #1;
            n_checks++;
            if (o_dmem_req !== 1'b1 || o_dmem_addr !== 32'h200 || o_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL lh%0d_issue: got req=%b addr=%h stall=%b want 1 00000200 1",
                         k, o_dmem_req, o_dmem_addr, o_stall);
            end
            @(posedge clk); #1;
            i_dmem_ready  = 1'b0;
            i_dmem_rvalid = 1'b1;
            i_dmem_rdata  = 32'h8001_1234;
            #1;
            n_checks++;
            if (o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL lh%0d_rvalid: got stall=%b req=%b want 0 0", k, o_stall, o_dmem_req);
            end
            @(posedge clk); #1;
            n_checks++;
            e = sb.pop_front();
            if (o_vld !== 1'b1 || o_rd_wen !== e.wen || o_misaligned !== e.mis || o_rd_waddr !== e.rd || o_wb_data !== e.wb) begin
                n_fail++;
                $display("FAIL lh%0d_wb: got vld=%b wen=%b mis=%b rd=%0d data=%h want vld=1 wen=%b mis=%b rd=%0d data=%h",
                         k, o_vld, o_rd_wen, o_misaligned, o_rd_waddr, o_wb_data, e.wen, e.mis, e.rd, e.wb);
            end
            i_dmem_rvalid = 1'b0;
            drive_idle();
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h201, 32'h0, 32'h201, 5'd9, 1'b1, 1'b1);
        sb.push_back('{wb: 32'h0, rd: 5'd9, wen: 1'b0, mis: 1'b1, chk: 1'b0});
        #1;
        n_checks++;
        if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_mis_port: got req=%b stall=%b want 0 0", o_dmem_req, o_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        e = sb.pop_front();
        if (o_vld !== 1'b1 || o_rd_wen !== e.wen || o_misaligned !== e.mis) begin
            n_fail++;
            $display("FAIL lw_mis_wb: got vld=%b wen=%b mis=%b want vld=1 wen=%b mis=%b",
                     o_vld, o_rd_wen, o_misaligned, e.wen, e.mis);
        end
        drive_idle();
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h300, 5'd11, 1'b1, 1'b1);
        i_dmem_ready = 1'b1;
        @(posedge clk); #1;
        i_dmem_ready = 1'b0;
        #1;
        n_checks++;
        if (o_stall !== 1'b1 || o_dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_wait: got stall=%b req=%b want 1 0", o_stall, o_dmem_req);
        end
        i_rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        i_rst = 1'b0;
        #1;
        n_checks++;
        if ({o_vld, o_rd_wen, o_misaligned, o_rd_waddr, o_wb_data, o_dmem_req, o_stall} !== 42'd0) begin
            n_fail++;
            $display("FAIL rstw_values: got vld=%b wen=%b mis=%b rd=%0d data=%h req=%b stall=%b want all zero",
                     o_vld, o_rd_wen, o_misaligned, o_rd_waddr, o_wb_data, o_dmem_req, o_stall);
        end
        @(posedge clk); #1;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h5555_5555;
        #1;
        n_checks++;
        if (o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_late_rvalid: got stall=%b req=%b want 0 0", o_stall, o_dmem_req);
        end
        @(posedge clk); #1;
        i_dmem_rvalid = 1'b0;
        n_checks++;
        if (o_vld !== 1'b0 || o_rd_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_no_wb: got vld=%b wen=%b want 0 0", o_vld, o_rd_wen);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        i_dmem_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h002, 32'h0000_BEEF, 32'h002, 5'd0, 1'b0, 1'b0);
        sb.push_back('{wb: 32'h0, rd: 5'd0, wen: 1'b0, mis: 1'b0, chk: 1'b0});
        #1;
        n_checks++;
        if ({o_dmem_req, o_dmem_wen, o_dmem_addr, o_dmem_mask, o_dmem_wdata, o_stall} !==
            {1'b1, 1'b1, 32'h0, 4'b1100, 32'hBEEF_BEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL sh_port: got req=%b wen=%b addr=%h mask=%b wdata=%h stall=%b want 1 1 00000000 1100 beefbeef 0",
                     o_dmem_req, o_dmem_wen, o_dmem_addr, o_dmem_mask, o_dmem_wdata, o_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        e = sb.pop_front();
        if (o_vld !== 1'b1 || o_rd_wen !== e.wen || o_misaligned !== e.mis) begin
            n_fail++;
            $display("FAIL sh_wb: got vld=%b wen=%b mis=%b want vld=1 wen=%b mis=%b",
                     o_vld, o_rd_wen, o_misaligned, e.wen, e.mis);
        end
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h004, 32'h0, 32'h004, 5'd10, 1'b1, 1'b1);
        sb.push_back('{wb: 32'hDEAD_BEEF, rd: 5'd10, wen: 1'b1, mis: 1'b0, chk: 1'b1});
        #1;
        n_checks++;
        if ({o_dmem_req, o_dmem_wen, o_dmem_addr, o_dmem_mask, o_stall} !== {1'b1, 1'b0, 32'h4, 4'b1111, 1'b1}) begin
            n_fail++;
            $display("FAIL lw_b2b_port: got req=%b wen=%b addr=%h mask=%b stall=%b want 1 0 00000004 1111 1",
                     o_dmem_req, o_dmem_wen, o_dmem_addr, o_dmem_mask, o_stall);
        end
        @(posedge clk); #1;
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (o_stall !== 1'b0 || o_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_b2b_wait: got stall=%b vld=%b want 0 0", o_stall, o_vld);
        end
        @(posedge clk); #1;
        n_checks++;
        e = sb.pop_front();
        if (o_vld !== 1'b1 || o_rd_wen !== e.wen || o_misaligned !== e.mis || o_rd_waddr !== e.rd || o_wb_data !== e.wb) begin
            n_fail++;
            $display("FAIL lw_b2b_wb: got vld=%b wen=%b mis=%b rd=%0d data=%h want vld=1 wen=%b mis=%b rd=%0d data=%h",
                     o_vld, o_rd_wen, o_misaligned, o_rd_waddr, o_wb_data, e.wen, e.mis, e.rd, e.wb);
        end
        i_dmem_rvalid = 1'b0;
        drive_idle();
    endtask

    initial begin
        i_rst         = 1'b1;
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = 32'h0;
        drive_idle();
        test_reset();
        test_alu_back_to_back();
        test_store_byte();
        test_load_byte();
        test_half_and_misaligned();
        test_reset_in_wait();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit forming the MEM stage of the RV32I pipeline. Consumes the EX/MEM register (address, store data, access size, read/write strobes), drives a variable-latency data-memory port with a request/ready/rvalid handshake, and aligns and extends load data. It produces the MEM/WB register and stalls upstream stages while a memory access is outstanding.

## Interface
- No parameters; XLEN fixed at 32.
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_vld  in  1  EX/MEM entry valid
- i_mem_read / i_mem_write  in  1/1  load / store strobes (never both)
- i_opsel  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_dmem_addr  in  32  byte address (ALU result)
- i_dmem_wdata  in  32  store data, unshifted (rs2)
- i_res  in  32  ALU result for non-memory instructions
- i_rd_waddr  in  5;  i_rd_wen  in  1;  i_mem_reg  in  1 (writeback select load data)
- o_stall  out  1  hold EX/MEM and earlier stages
- o_dmem_req  out  1  request valid
- o_dmem_wen  out  1  1 = store, 0 = load
- o_dmem_addr  out  32  word address, bits [1:0] = 0
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_mask  out  4  byte enables (loads: 1111)
- i_dmem_ready  in  1  request accepted this cycle
- i_dmem_rvalid  in  1  load data valid
- i_dmem_rdata  in  32  load word
- o_vld  out  1  MEM/WB entry valid
- o_rd_waddr  out  5;  o_rd_wen  out  1
- o_wb_data  out  32  writeback value
- o_misaligned  out  1  misaligned-access flag, qualified by o_vld

## Operation
- FSM states: IDLE, REQ (waiting on ready), WAIT (load waiting on rvalid).
- A memory op is i_vld & (i_mem_read | i_mem_write). Misaligned means H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0.
- IDLE:
  - Aligned memory op: assert o_dmem_req combinationally.
    - Ready and store: the op completes this cycle and the FSM stays in IDLE.
    - Ready and load: go to WAIT.
    - Not ready: go to REQ.
  - Misaligned op: no request. At the next edge, o_vld = 1, o_misaligned = 1, o_rd_wen = 0.
  - Non-memory valid op: at the next edge, o_wb_data = i_res, o_vld = 1, o_rd_wen = i_rd_wen.
- REQ: hold o_dmem_req and all o_dmem_* outputs stable until ready.
  - Ready and store: go to IDLE; the op completes.
  - Ready and load: go to WAIT.
- WAIT: no request. On rvalid, the load completes and the FSM goes to IDLE.
- Store lanes:
  - B: wdata = {4{d[7:0]}}, mask = 0001 << addr[1:0].
  - H: wdata = {2{d[15:0]}}, mask = 0011 or 1100 per addr[1].
  - W: wdata = d, mask = 1111.
- Load extract: shift rdata right by 8·addr[1:0], using the address latched at request issue.
  - B / H: sign-extend.
  - BU / HU: zero-extend.
  - W: pass through.
- Load completion: o_wb_data = extracted value when i_mem_reg = 1, else i_res. o_vld = 1.
- o_stall = 1 whenever the current EX/MEM op does not complete this cycle. This covers IDLE-not-ready, REQ-not-ready, WAIT-no-rvalid, and IDLE-ready-load.
- While stalled, upstream holds all i_* inputs stable.
- Each cycle without a completing op loads a bubble into MEM/WB: o_vld = 0, o_rd_wen = 0.
- i_dmem_rvalid outside WAIT is ignored. At most one access is outstanding.

## Timing
- Reset values: state IDLE, o_vld 0, o_rd_wen 0, o_misaligned 0, o_rd_waddr 0, o_wb_data 0, o_dmem_req 0, o_stall 0.
- Reset has priority over every transition. Reset in REQ/WAIT abandons the access; the rvalid that later arrives is dropped.
- Non-memory and misaligned ops: 1-cycle latency to MEM/WB, no stall.
- Store with ready in the issue cycle: 1-cycle latency, no stall. Each ready-wait cycle adds 1.
- Load: result in MEM/WB at the edge after rvalid. Minimum stall is 1 cycle (ready at issue, rvalid next cycle).
- o_dmem_* are combinational in IDLE and held from registers in REQ.
- Latched request fields: addr[1:0], opsel, rd_waddr, rd_wen, mem_reg.
- Back-to-back memory ops: the next op may issue in the cycle following completion.

## Test plan
- Back-to-back ALU ops, i_res = 0x1234_5678 then 0xCAFE_0000: MEM/WB shows each one cycle later, o_stall never asserted.
- SB at 0x103, d = 0xAA, ready at issue: req = 1, wen = 1, addr = 0x100, mask = 1000, wdata = 0xAAAA_AAAA, no stall, o_vld = 1 next cycle.
- LB at 0x102, ready after 2 cycles, rvalid 3 cycles later, rdata = 0x0080_0000: o_wb_data = 0xFFFF_FF80, stall held until rvalid cycle, req and addr stable in REQ.
- LHU at 0x202, rdata = 0x8001_xxxx: o_wb_data = 0x0000_8001. LW at 0x201: no req, o_misaligned = 1, o_rd_wen = 0.
- Reset asserted in WAIT, rvalid arriving 2 cycles later: all outputs return to reset values, rvalid ignored, no writeback.
- SH at 0x002, ready at issue, followed immediately by LW at 0x004: second request issues the following cycle, mask = 1100 then 1111.
